// File: rtl/level_classifier_pipe.sv
// Multi-lane CABAC level classifier with valid/ready streaming and per-block statistics.
// Each accepted beat is classified into ZERO/ONE/TWO/MID/BASEPLUS per lane. The classes
// and remainder symbols go through a 2-entry output FIFO. Significance and level-sum
// totals are accumulated per coefficient block.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                input handshake (in_ready = buffer not full)
//   in_abs_level, in_lane_en         per-lane absolute levels and lane enables
//   in_base_level, in_last           beat base level, last-beat-of-block marker
//   out_valid/out_ready              output handshake
//   out_case, out_symbol             per-lane class (3 bits) and remainder symbol
//   out_lane_en, out_last            lane enables and last flag carried with the beat
//   blk_valid, blk_num_sig,
//   blk_sum_abs, blk_sat             one-cycle block statistics report
module level_classifier_pipe #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned LEVEL_W = 16,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned SUM_W   = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*LEVEL_W-1:0]   in_abs_level,
    input  logic [LANES-1:0]           in_lane_en,
    input  logic [7:0]                 in_base_level,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*3-1:0]         out_case,
    output logic [LANES*LEVEL_W-1:0]   out_symbol,
    output logic [LANES-1:0]           out_lane_en,
    output logic                       out_last,
    output logic                       blk_valid,
    output logic [CNT_W-1:0]           blk_num_sig,
    output logic [SUM_W-1:0]           blk_sum_abs,
    output logic                       blk_sat
);

    localparam int unsigned PCNT_W = $clog2(LANES + 1);
    localparam int unsigned BSUM_W = LEVEL_W + $clog2(LANES + 1);

    typedef struct packed {
        logic [LANES*3-1:0]       cls;
        logic [LANES*LEVEL_W-1:0] sym;
        logic [LANES-1:0]         en;
        logic                     last;
    } beat_t;

    beat_t              beat_in;
    beat_t              mem [2];
    logic [LEVEL_W-1:0] base_eff;
    logic [PCNT_W-1:0]  beat_sig;
    logic [BSUM_W-1:0]  beat_sum;
    logic [1:0]         count;
    logic [1:0]         count_next;
    logic               wr_ptr;
    logic               rd_ptr;
    logic               push;
    logic               pop;

    logic [CNT_W-1:0]   acc_sig;
    logic [SUM_W-1:0]   acc_sum;
    logic               acc_sat;
    logic [CNT_W:0]     sig_add;
    logic [SUM_W:0]     sum_add;
    logic [CNT_W-1:0]   sig_new;
    logic [SUM_W-1:0]   sum_new;
    logic               sig_ovf;
    logic               sum_ovf;

    // Per-lane classification and beat statistics; disabled lanes read as ZERO.
    always_comb begin
        base_eff = (in_base_level < 8'd3) ? LEVEL_W'(3) : LEVEL_W'(in_base_level);
        beat_in  = '0;
        beat_sig = '0;
        beat_sum = '0;
        beat_in.en   = in_lane_en;
        beat_in.last = in_last;
        for (int i = 0; i < LANES; i++) begin
            if (in_lane_en[i]) begin
                if (in_abs_level[i*LEVEL_W +: LEVEL_W] == LEVEL_W'(0)) begin
                    beat_in.cls[i*3 +: 3] = 3'd0;
                end else if (in_abs_level[i*LEVEL_W +: LEVEL_W] == LEVEL_W'(1)) begin
                    beat_in.cls[i*3 +: 3] = 3'd1;
                end else if (in_abs_level[i*LEVEL_W +: LEVEL_W] == LEVEL_W'(2)) begin
                    beat_in.cls[i*3 +: 3] = 3'd2;
                end else if (in_abs_level[i*LEVEL_W +: LEVEL_W] < base_eff) begin
                    beat_in.cls[i*3 +: 3]           = 3'd3;
                    beat_in.sym[i*LEVEL_W +: LEVEL_W] =
                        in_abs_level[i*LEVEL_W +: LEVEL_W] - LEVEL_W'(3);
                end else begin
                    beat_in.cls[i*3 +: 3]           = 3'd4;
                    beat_in.sym[i*LEVEL_W +: LEVEL_W] =
                        in_abs_level[i*LEVEL_W +: LEVEL_W] - base_eff;
                end
                if (in_abs_level[i*LEVEL_W +: LEVEL_W] != LEVEL_W'(0)) begin
                    beat_sig = beat_sig + PCNT_W'(1);
                end
                beat_sum = beat_sum + BSUM_W'(in_abs_level[i*LEVEL_W +: LEVEL_W]);
            end
        end
    end

    // Saturating accumulation including the current beat.
    always_comb begin
        sig_add = {1'b0, acc_sig} + (CNT_W+1)'(beat_sig);
        sum_add = {1'b0, acc_sum} + (SUM_W+1)'(beat_sum);
        sig_ovf = sig_add[CNT_W];
        sum_ovf = sum_add[SUM_W];
        sig_new = sig_ovf ? '1 : sig_add[CNT_W-1:0];
        sum_new = sum_ovf ? '1 : sum_add[SUM_W-1:0];
    end

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // 2-entry FIFO; ready/valid are flops derived from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= beat_in;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count     <= count_next;
            in_ready  <= (count_next != 2'd2);
            out_valid <= (count_next != 2'd0);
        end
    end

    assign out_case    = mem[rd_ptr].cls;
    assign out_symbol  = mem[rd_ptr].sym;
    assign out_lane_en = mem[rd_ptr].en;
    assign out_last    = mem[rd_ptr].last;

    // Block statistics: a last beat reports its totals and restarts the accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sig     <= '0;
            acc_sum     <= '0;
            acc_sat     <= 1'b0;
            blk_valid   <= 1'b0;
            blk_num_sig <= '0;
            blk_sum_abs <= '0;
            blk_sat     <= 1'b0;
        end else begin
            blk_valid <= 1'b0;
            if (push) begin
                if (in_last) begin
                    blk_valid   <= 1'b1;
                    blk_num_sig <= sig_new;
                    blk_sum_abs <= sum_new;
                    blk_sat     <= acc_sat | sig_ovf | sum_ovf;
                    acc_sig     <= '0;
                    acc_sum     <= '0;
                    acc_sat     <= 1'b0;
                end else begin
                    acc_sig <= sig_new;
                    acc_sum <= sum_new;
                    acc_sat <= acc_sat | sig_ovf | sum_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_level_classifier_pipe.sv
// Directed self-checking bench for level_classifier_pipe.
module tb_level_classifier_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_abs_level;
    logic [3:0]  in_lane_en;
    logic [7:0]  in_base_level;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_case;
    logic [63:0] out_symbol;
    logic [3:0]  out_lane_en;
    logic        out_last;
    logic        blk_valid;
    logic [7:0]  blk_num_sig;
    logic [19:0] blk_sum_abs;
    logic        blk_sat;

    int n_chk  = 0;
    int n_pass = 0;

    level_classifier_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_abs_level  (in_abs_level),
        .in_lane_en    (in_lane_en),
        .in_base_level (in_base_level),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_case      (out_case),
        .out_symbol    (out_symbol),
        .out_lane_en   (out_lane_en),
        .out_last      (out_last),
        .blk_valid     (blk_valid),
        .blk_num_sig   (blk_num_sig),
        .blk_sum_abs   (blk_sum_abs),
        .blk_sat       (blk_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present one beat for one edge; called #1 after a posedge with in_ready=1.
    task automatic send(input logic [63:0] lv, input logic [3:0] en,
                        input logic [7:0] base, input logic last);
        in_abs_level  = lv;
        in_lane_en    = en;
        in_base_level = base;
        in_last       = last;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_abs_level = '0; in_lane_en = '0; in_base_level = '0; in_last = 1'b0;
        #22;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_blk_valid", 64'(blk_valid), 64'd0);
        check("rst_blk_sum",   64'(blk_sum_abs), 64'd0);
        check("rst_out_case",  64'(out_case),  64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Lanes {0,1,2,5}, base 4
        send({16'd5, 16'd2, 16'd1, 16'd0}, 4'hF, 8'd4, 1'b1);
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_case", 64'(out_case), 64'({3'd4, 3'd2, 3'd1, 3'd0}));
        check("t1_sym",  out_symbol, {16'd1, 16'd0, 16'd0, 16'd0});
        check("t1_last", 64'(out_last), 64'd1);
        check("t1_blk_valid", 64'(blk_valid), 64'd1);
        check("t1_num_sig", 64'(blk_num_sig), 64'd3);
        check("t1_sum", 64'(blk_sum_abs), 64'd8);
        @(posedge clk); #1;
        check("t1_blk_pulse", 64'(blk_valid), 64'd0);
        check("t1_popped", 64'(out_valid), 64'd0);
        check("t1_blk_hold", 64'(blk_sum_abs), 64'd8);

        // Effective base clamping
        send(64'd3, 4'h1, 8'd5, 1'b1);
        check("mid_case", 64'(out_case[2:0]), 64'd3);
        check("mid_sym",  64'(out_symbol[15:0]), 64'd0);
        send(64'd3, 4'h1, 8'd1, 1'b1);
        check("bp_case", 64'(out_case[2:0]), 64'd4);
        check("bp_sym",  64'(out_symbol[15:0]), 64'd0);
        check("bp_back2back_blk", 64'(blk_valid), 64'd1);
        check("bp_back2back_sum", 64'(blk_sum_abs), 64'd3);

        // Sum saturation: 5 beats of 4 x 16'hFFFF
        for (int i = 0; i < 5; i++) send({4{16'hFFFF}}, 4'hF, 8'd4, (i == 4));
        check("sat_blk_valid", 64'(blk_valid), 64'd1);
        check("sat_sum", 64'(blk_sum_abs), 64'hFFFFF);
        check("sat_flag", 64'(blk_sat), 64'd1);
        check("sat_num_sig", 64'(blk_num_sig), 64'd20);
        send(64'd1, 4'hF, 8'd4, 1'b1);
        check("sat_next_flag", 64'(blk_sat), 64'd0);
        check("sat_next_sum", 64'(blk_sum_abs), 64'd1);

        // Partial lane enable
        send({4{16'd7}}, 4'b0101, 8'd4, 1'b1);
        check("en_case", 64'(out_case), 64'({3'd0, 3'd4, 3'd0, 3'd4}));
        check("en_sym",  out_symbol, {16'd0, 16'd3, 16'd0, 16'd3});
        check("en_lane_en", 64'(out_lane_en), 64'h5);
        check("en_num_sig", 64'(blk_num_sig), 64'd2);
        check("en_sum", 64'(blk_sum_abs), 64'd14);
        @(posedge clk); #1;

        // Backpressure: A=10, B=11, C=12 at base 3 -> symbols 7, 8, 9
        out_ready = 1'b0;
        send(64'd10, 4'h1, 8'd3, 1'b0);
        send(64'd11, 4'h1, 8'd3, 1'b0);
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_full_sym", 64'(out_symbol[15:0]), 64'd7);
        in_abs_level = 64'd12; in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp_stall_ready", 64'(in_ready), 64'd0);
        check("bp_stall_sym", 64'(out_symbol[15:0]), 64'd7);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_pop_a", 64'(out_symbol[15:0]), 64'd8);
        check("bp_ready_again", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_pop_b", 64'(out_symbol[15:0]), 64'd9);
        check("bp_c_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        check("bp_drained", 64'(out_valid), 64'd0);

        // Reset with two buffered beats and an open block
        out_ready = 1'b0;
        send(64'd100, 4'h1, 8'd4, 1'b0);
        send(64'd100, 4'h1, 8'd4, 1'b0);
        check("mr_buffered", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_in_ready", 64'(in_ready), 64'd1);
        check("mr_blk_valid", 64'(blk_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(64'd5, 4'h1, 8'd4, 1'b1);
        check("mr_blk_valid_after", 64'(blk_valid), 64'd1);
        check("mr_sum", 64'(blk_sum_abs), 64'd5);
        check("mr_num_sig", 64'(blk_num_sig), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
